// File: rtl/ber_checker_if.sv
// ber_checker_if: sample-side bus of the BER checker.
// master drives the strobe/sample/phase, slave returns slicer decisions,
// lock status, the search delay and the running bit/error totals.
interface ber_checker_if #(
  parameter int NB_DATA  = 13,
  parameter int NB_PHASE = 3,
  parameter int NB_DELAY = 4,
  parameter int NB_CNT   = 32
);
  logic                       i_enable;
  logic signed [NB_DATA-1:0]  i_data;
  logic [NB_PHASE-1:0]        i_phase;
  logic                       o_bit;
  logic                       o_bit_valid;
  logic                       o_locked;
  logic [NB_DELAY-1:0]        o_delay;
  logic [NB_CNT-1:0]          o_bit_count;
  logic [NB_CNT-1:0]          o_err_count;

  modport master (
    output i_enable, i_data, i_phase,
    input  o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count
  );
  modport slave (
    input  i_enable, i_data, i_phase,
    output o_bit, o_bit_valid, o_locked, o_delay, o_bit_count, o_err_count
  );
endinterface

// File: rtl/ber_checker.sv
// ber_checker: decimate oversampled FIR output at a selectable phase, slice
// by sign, align against a local PRBS9 (x^9+x^5+1) replica by stepping a
// candidate delay once per dirty window, then count bits/errors once locked.
// Optional macro BER_LOSS_OF_LOCK_EN: keep monitoring windows while locked and
// drop back to search when a window exceeds ERR_THR errors.
module ber_checker #(
  parameter int          NB_DATA   = 13,
  parameter int          OVER_SAMP = 8,
  parameter int          NB_PHASE  = 3,
  parameter logic [8:0]  PRBS_SEED = 9'h1AA,
  parameter int          NB_DELAY  = 4,
  parameter int          WIN_LEN   = 64,
  parameter int          ERR_THR   = 8,
  parameter int          NB_CNT    = 32
) (
  input  logic           clk,
  input  logic           i_rst_n,
  ber_checker_if.slave   bus
);
  localparam int DEPTH  = 1 << NB_DELAY;
  localparam int NB_WIN = $clog2(WIN_LEN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              state_q;
  logic [NB_PHASE-1:0] samp_cnt_q, phase_q;
  logic [8:0]          prbs_q;
  logic [DEPTH-2:0]    dline_q;   // older reference bits; newest bit is combinational
  logic [NB_WIN-1:0]   win_cnt_q, err_win_q;
  logic [NB_DELAY-1:0] delay_q;
  logic [NB_CNT-1:0]   bit_cnt_q, err_cnt_q;
  logic                bit_q, bit_vld_q, locked_q;

  logic                strobe, dec, prbs_bit, ref_bit, mism, win_end, bit_sat, err_sat;
  logic [DEPTH-1:0]    dline_d;
  logic [NB_WIN-1:0]   win_cnt_d, err_win_d;

  assign strobe    = bus.i_enable && (samp_cnt_q == phase_q);
  // negative sample -> 1; zero slices to 0
  assign dec       = $signed(bus.i_data) < $signed({NB_DATA{1'b0}});
  assign prbs_bit  = prbs_q[8] ^ prbs_q[4];
  // index 0 is the bit generated on this strobe, index d is d strobes old
  assign dline_d   = {dline_q, prbs_bit};
  assign ref_bit   = dline_d[delay_q];
  assign mism      = dec ^ ref_bit;
  assign win_cnt_d = win_cnt_q + NB_WIN'(1);
  assign err_win_d = err_win_q + NB_WIN'(mism);
  assign win_end   = (win_cnt_d == NB_WIN'(WIN_LEN));
  assign bit_sat   = &bit_cnt_q;
  assign err_sat   = &err_cnt_q;

  // Sample counter within a symbol; phase is re-latched only at symbol start
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      samp_cnt_q <= '0;
      phase_q    <= '0;
    end else if (bus.i_enable) begin
      if (samp_cnt_q == NB_PHASE'(OVER_SAMP - 1)) begin
        samp_cnt_q <= '0;
        phase_q    <= bus.i_phase;
      end else begin
        samp_cnt_q <= samp_cnt_q + NB_PHASE'(1);
      end
    end
  end

  // Reference PRBS and its delay line advance once per symbol strobe
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prbs_q  <= PRBS_SEED;
      dline_q <= '0;
    end else if (strobe) begin
      prbs_q  <= {prbs_q[7:0], prbs_bit};
      dline_q <= dline_d[DEPTH-2:0];
    end
  end

  // Slicer output register: decision held between one-cycle valid pulses
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_q     <= 1'b0;
      bit_vld_q <= 1'b0;
    end else begin
      bit_vld_q <= strobe;
      if (strobe) bit_q <= dec;
    end
  end

  // Search/lock FSM with window and total counters
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= SEARCH;
      locked_q  <= 1'b0;
      delay_q   <= '0;
      win_cnt_q <= '0;
      err_win_q <= '0;
      bit_cnt_q <= '0;
      err_cnt_q <= '0;
    end else if (strobe) begin
      case (state_q)
        SEARCH: begin
          if (win_end) begin
            win_cnt_q <= '0;
            err_win_q <= '0;
            if (err_win_d == '0) begin
              state_q   <= LOCKED;
              locked_q  <= 1'b1;
              bit_cnt_q <= '0;
              err_cnt_q <= '0;
            end else begin
              delay_q <= delay_q + NB_DELAY'(1);
            end
          end else begin
            win_cnt_q <= win_cnt_d;
            err_win_q <= err_win_d;
          end
        end
        LOCKED: begin
          // a saturated bit count freezes both totals
          if (!bit_sat) begin
            bit_cnt_q <= bit_cnt_q + NB_CNT'(1);
            if (mism && !err_sat) err_cnt_q <= err_cnt_q + NB_CNT'(1);
          end
`ifdef BER_LOSS_OF_LOCK_EN
          if (win_end) begin
            win_cnt_q <= '0;
            err_win_q <= '0;
            if (err_win_d > NB_WIN'(ERR_THR)) begin
              state_q  <= SEARCH;
              locked_q <= 1'b0;
              delay_q  <= delay_q + NB_DELAY'(1);
            end
          end else begin
            win_cnt_q <= win_cnt_d;
            err_win_q <= err_win_d;
          end
`endif
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign bus.o_bit       = bit_q;
  assign bus.o_bit_valid = bit_vld_q;
  assign bus.o_locked    = locked_q;
  assign bus.o_delay     = delay_q;
  assign bus.o_bit_count = bit_cnt_q;
  assign bus.o_err_count = err_cnt_q;
endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: drives a sign-mapped PRBS9 symbol stream through a symbol
// delay into two checkers (32-bit and 8-bit counters) and compares against a
// window-level search/count model of the checker.
module tb_ber_checker;
  localparam int MAXS = 4096;

  logic clk = 1'b0;
  logic i_rst_n;
  always #5 clk = ~clk;

  ber_checker_if #(.NB_CNT(32)) ifc();
  ber_checker_if #(.NB_CNT(8))  ifc8();
  assign ifc8.i_enable = ifc.i_enable;
  assign ifc8.i_data   = ifc.i_data;
  assign ifc8.i_phase  = ifc.i_phase;

  ber_checker #(.NB_CNT(32)) dut  (.clk(clk), .i_rst_n(i_rst_n), .bus(ifc.slave));
  ber_checker #(.NB_CNT(8))  dut8 (.clk(clk), .i_rst_n(i_rst_n), .bus(ifc8.slave));

  int n_chk = 0, n_fail = 0;
  bit ref_b [MAXS];
  bit ch    [MAXS];
  bit obs_b [MAXS];
  int obs_pos [MAXS], obs_nv [MAXS], exp_ph [MAXS];
  int sym, ph_drv, ph_cur, link_d, flip_at;

  // TX generator: seed-matched PRBS9, one bit per symbol
  function automatic void gen_ref();
    logic [8:0] s;
    bit nb;
    s = 9'h1AA;
    for (int k = 0; k < MAXS; k++) begin
      nb = s[8] ^ s[4];
      ref_b[k] = nb;
      s = {s[7:0], nb};
    end
  endfunction

  function automatic bit refd(input int i);
    return (i < 0) ? 1'b0 : ref_b[i];
  endfunction

  // Channel: random bits until the link delay fills, then delayed TX with optional flip
  function automatic bit chan_bit();
    if (sym < link_d) return 1'($urandom);
    return ref_b[sym - link_d] ^ (sym == flip_at);
  endfunction

  // Checker model over ch[0..n-1]: 64-symbol windows stepping delay until clean,
  // then saturating totals from the lock point on.
  function automatic void model(input int n, input longint maxc, output bit lk,
                                output int dly, output longint bc, output longint ec);
    int e, lock_at;
    lk = 0; dly = 0; bc = 0; ec = 0; lock_at = n;
    for (int ws = 0; ws + 64 <= n && !lk; ws += 64) begin
      e = 0;
      for (int k = ws; k < ws + 64; k++) if (ch[k] != refd(k - dly)) e++;
      if (e == 0) begin lk = 1; lock_at = ws + 64; end
      else dly = (dly + 1) % 16;
    end
    for (int k = lock_at; k < n; k++)
      if (bc < maxc) begin
        bc++;
        if (ch[k] != refd(k - dly) && ec < maxc) ec++;
      end
  endfunction

  task automatic send_symbol(input bit b, input bit gap, input int chg_at, input int chg_ph);
    int nv, pos, v;
    bit ob;
    nv = 0; pos = -1; ob = 0;
    for (int s = 0; s < 8; s++) begin
      if (s == chg_at) ph_drv = chg_ph;
      if (b) v = -int'($urandom_range(4095, 1));
      else   v = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(4095, 1));
      ifc.i_phase  = 3'(ph_drv);
      ifc.i_enable = 1'b1;
      ifc.i_data   = 13'(v);
      @(posedge clk); #1;
      if (ifc.o_bit_valid) begin nv++; pos = s; ob = ifc.o_bit; end
      if (gap) begin
        ifc.i_enable = 1'b0;
        ifc.i_data   = 13'($urandom);
        @(posedge clk); #1;
        if (ifc.o_bit_valid) nv += 100;
      end
    end
    ch[sym] = b; obs_b[sym] = ob; obs_pos[sym] = pos; obs_nv[sym] = nv;
    exp_ph[sym] = ph_cur;
    ph_cur = ph_drv;   // value present on the last sample is latched at wrap
    sym++;
  endtask

  task automatic run_syms(input int n, input bit gap);
    for (int i = 0; i < n; i++) send_symbol(chan_bit(), gap, -1, 0);
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    ifc.i_enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    sym = 0; ph_cur = 0; flip_at = -1;
  endtask

  task automatic test_reset();
    logic [77:0] o, o8;
    #1 i_rst_n = 1'b0;
    for (int c = 0; c < 12; c++) begin
      ifc.i_enable = 1'($urandom);
      ifc.i_data   = 13'($urandom);
      ifc.i_phase  = 3'($urandom);
      @(posedge clk); #1;
      o  = {ifc.o_bit, ifc.o_bit_valid, ifc.o_locked, 7'(ifc.o_delay), ifc.o_bit_count, ifc.o_err_count};
      o8 = {ifc8.o_bit, ifc8.o_bit_valid, ifc8.o_locked, 7'(ifc8.o_delay), 26'd0,
            24'(ifc8.o_bit_count), 24'(ifc8.o_err_count)};
      n_chk++;
      if (o !== '0 || o8 !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %h / %h want 0", c, o, o8);
      end
    end
    ifc.i_enable = 1'b0;
  endtask

  task automatic check_symbols(input string nm, input int from, input int to);
    for (int k = from; k < to; k++) begin
      n_chk++;
      if (obs_b[k] !== ch[k] || obs_pos[k] !== exp_ph[k] || obs_nv[k] !== 1) begin
        n_fail++;
        $display("FAIL %s sym %0d: bit %0b pos %0d pulses %0d, want bit %0b pos %0d pulses 1",
                 nm, k, obs_b[k], obs_pos[k], obs_nv[k], ch[k], exp_ph[k]);
      end
    end
  endtask

  task automatic test_clean_loopback();
    bit lk; int dly; longint bc, ec;
    do_reset();
    ph_drv = 3; link_d = 5;
    run_syms(383, 0);
    model(sym, 64'hFFFF_FFFF, lk, dly, bc, ec);
    n_chk++;
    if (ifc.o_locked !== lk) begin n_fail++; $display("FAIL clean_prelock: locked %0b want %0b", ifc.o_locked, lk); end
    run_syms(1, 0);
    n_chk++;
    if (ifc.o_locked !== 1'b1) begin n_fail++; $display("FAIL clean_lock_6win: locked %0b want 1", ifc.o_locked); end
    run_syms(1116, 0);
    model(sym, 64'hFFFF_FFFF, lk, dly, bc, ec);
    n_chk++;
    if (ifc.o_locked !== lk || ifc.o_delay !== 4'(dly) || ifc.o_delay !== 4'd5) begin
      n_fail++; $display("FAIL clean_delay: locked %0b delay %0d want %0b %0d", ifc.o_locked, ifc.o_delay, lk, dly);
    end
    n_chk++;
    if (ifc.o_bit_count !== 32'(bc) || ifc.o_err_count !== 32'(ec) || ifc.o_err_count !== 0) begin
      n_fail++; $display("FAIL clean_counts: bits %0d errs %0d want %0d %0d", ifc.o_bit_count, ifc.o_err_count, bc, ec);
    end
    check_symbols("clean_slice", 0, sym);
  endtask

  task automatic test_saturation();
    bit lk; int dly; longint bc, ec;
    model(sym, 255, lk, dly, bc, ec);
    n_chk++;
    if (ifc8.o_bit_count !== 8'(bc) || ifc8.o_bit_count !== 8'hFF || ifc8.o_err_count !== 8'(ec)) begin
      n_fail++; $display("FAIL sat_counts: bits %0d errs %0d want %0d %0d", ifc8.o_bit_count, ifc8.o_err_count, bc, ec);
    end
  endtask

  task automatic test_single_error();
    bit lk; int dly; longint bc, ec;
    logic [31:0] e0;
    e0 = ifc.o_err_count;
    flip_at = sym + 10;
    run_syms(100, 0);
    model(sym, 64'hFFFF_FFFF, lk, dly, bc, ec);
    n_chk++;
    if (ifc.o_err_count !== e0 + 1 || ifc.o_err_count !== 32'(ec)) begin
      n_fail++; $display("FAIL single_err: errs %0d want %0d", ifc.o_err_count, e0 + 1);
    end
    n_chk++;
    if (ifc.o_locked !== 1'b1 || ifc.o_bit_count !== 32'(bc)) begin
      n_fail++; $display("FAIL single_err_lock: locked %0b bits %0d want 1 %0d", ifc.o_locked, ifc.o_bit_count, bc);
    end
    n_chk++;
    if (ifc8.o_bit_count !== 8'hFF || ifc8.o_err_count !== 8'd0) begin
      n_fail++; $display("FAIL sat_frozen: bits %0d errs %0d want 255 0", ifc8.o_bit_count, ifc8.o_err_count);
    end
    check_symbols("single_slice", sym - 100, sym);
  endtask

  task automatic test_enable_gaps();
    bit lk; int dly; longint bc, ec;
    do_reset();
    ph_drv = 3; link_d = 5;
    for (int i = 0; i < 450; i++)
      send_symbol(chan_bit(), 1'b1, (i % 50 == 25) ? int'($urandom_range(6, 1)) : -1, int'($urandom_range(7, 0)));
    model(sym, 64'hFFFF_FFFF, lk, dly, bc, ec);
    n_chk++;
    if (ifc.o_locked !== lk || ifc.o_delay !== 4'(dly) || ifc.o_bit_count !== 32'(bc) ||
        ifc.o_err_count !== 32'(ec) || ifc.o_bit_count !== 32'd66) begin
      n_fail++;
      $display("FAIL gaps_state: locked %0b delay %0d bits %0d errs %0d want %0b %0d %0d %0d",
               ifc.o_locked, ifc.o_delay, ifc.o_bit_count, ifc.o_err_count, lk, dly, bc, ec);
    end
    check_symbols("gaps_slice", 0, sym);
  endtask

  task automatic test_random_delay();
    bit lk; int dly; longint bc, ec;
    do_reset();
    link_d = $urandom_range(15, 0);
    ph_drv = $urandom_range(7, 0);
    run_syms(1100, 0);
    model(sym, 64'hFFFF_FFFF, lk, dly, bc, ec);
    n_chk++;
    if (ifc.o_locked !== 1'b1 || ifc.o_delay !== 4'(link_d) || ifc.o_delay !== 4'(dly)) begin
      n_fail++; $display("FAIL rand_delay: locked %0b delay %0d want 1 %0d", ifc.o_locked, ifc.o_delay, link_d);
    end
    n_chk++;
    if (ifc.o_bit_count !== 32'(bc) || ifc.o_err_count !== 32'(ec)) begin
      n_fail++; $display("FAIL rand_counts: bits %0d errs %0d want %0d %0d", ifc.o_bit_count, ifc.o_err_count, bc, ec);
    end
    check_symbols("rand_slice", 0, sym);
  endtask

  initial begin
    i_rst_n = 1'b0;
    ifc.i_enable = 1'b0;
    ifc.i_data   = '0;
    ifc.i_phase  = '0;
    sym = 0; ph_drv = 0; ph_cur = 0; link_d = 0; flip_at = -1;
    gen_ref();
    @(posedge clk);
    test_reset();
    test_clean_loopback();
    test_saturation();
    test_single_error();
    test_enable_gaps();
    test_random_delay();
    test_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
